alarm_bank: RTL and testbench

- Multi-channel alarm scheduler that sits beside the clock core.
- Accepts BCD alarm settings, converts them through the existing time2stamp module, and rolls each alarm forward by whole periods until it lies in the future.
- Stores NUM_ALARMS alarm stamps, compares each against the running seconds counter, and raises sticky ring flags.
- Supports one-shot and daily-repeat modes and per-channel cancel.

---
 rtl/alarm_bank_if.sv | 47 ++++
 rtl/alarm_bank.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_alarm_bank.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_bank_if.sv
// Load, cancel, acknowledge and status bundle for alarm_bank.
// Snooze signals exist only when ALARM_SNOOZE_EN is defined.
interface alarm_bank_if #(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned CHAN_W     = 2
);
    logic                  ld_valid;
    logic                  ld_ready;
    logic [CHAN_W-1:0]     ld_chan;
    logic                  ld_mode;
    logic [15:0]           ld_year_bcd;
    logic [7:0]            ld_month_bcd;
    logic [7:0]            ld_day_bcd;
    logic [7:0]            ld_hour_bcd;
    logic [7:0]            ld_minute_bcd;
    logic [7:0]            ld_second_bcd;
    logic                  ld_done;
    logic                  ld_err;
    logic                  cancel_valid;
    logic [CHAN_W-1:0]     cancel_chan;
    logic [NUM_ALARMS-1:0] ack;
    logic [NUM_ALARMS-1:0] armed;
    logic [NUM_ALARMS-1:0] ring;
    logic                  ring_any;
`ifdef ALARM_SNOOZE_EN
    logic                  snooze_valid;
    logic [CHAN_W-1:0]     snooze_chan;
`endif

    modport master (
        output ld_valid, ld_chan, ld_mode, ld_year_bcd, ld_month_bcd, ld_day_bcd,
               ld_hour_bcd, ld_minute_bcd, ld_second_bcd, cancel_valid, cancel_chan, ack,
`ifdef ALARM_SNOOZE_EN
        output snooze_valid, snooze_chan,
`endif
        input  ld_ready, ld_done, ld_err, armed, ring, ring_any
    );

    modport slave (
        input  ld_valid, ld_chan, ld_mode, ld_year_bcd, ld_month_bcd, ld_day_bcd,
               ld_hour_bcd, ld_minute_bcd, ld_second_bcd, cancel_valid, cancel_chan, ack,
`ifdef ALARM_SNOOZE_EN
        input  snooze_valid, snooze_chan,
`endif
        output ld_ready, ld_done, ld_err, armed, ring, ring_any
    );
endinterface

// File: rtl/alarm_bank.sv
// Multi-channel alarm scheduler: BCD load -> stamp -> roll-forward -> store, per-channel match/ring.
// Optional snooze support is enabled with the ALARM_SNOOZE_EN macro.
module time2stamp #(
    parameter int unsigned STAMP_W = 64
) (
    input  logic [13:0]        year_i,
    input  logic [3:0]         month_i,
    input  logic [4:0]         day_i,
    input  logic [4:0]         hour_i,
    input  logic [5:0]         minute_i,
    input  logic [5:0]         second_i,
    output logic [STAMP_W-1:0] stamp_o
);
    logic [STAMP_W-1:0] y;
    logic [STAMP_W-1:0] doy;
    logic [STAMP_W-1:0] days;

    // Year counted from March so the leap day is last; day 0 is 1970-01-01.
    always_comb begin
        y = STAMP_W'(year_i) - ((month_i <= 4'd2) ? STAMP_W'(1) : '0);
        case (month_i)
            4'd3:    doy = STAMP_W'(0);
            4'd4:    doy = STAMP_W'(31);
            4'd5:    doy = STAMP_W'(61);
            4'd6:    doy = STAMP_W'(92);
            4'd7:    doy = STAMP_W'(122);
            4'd8:    doy = STAMP_W'(153);
            4'd9:    doy = STAMP_W'(184);
            4'd10:   doy = STAMP_W'(214);
            4'd11:   doy = STAMP_W'(245);
            4'd12:   doy = STAMP_W'(275);
            4'd1:    doy = STAMP_W'(306);
            4'd2:    doy = STAMP_W'(337);
            default: doy = '0;
        endcase
        days = STAMP_W'(365) * y + y / STAMP_W'(4) - y / STAMP_W'(100) + y / STAMP_W'(400)
             + doy + STAMP_W'(day_i) - STAMP_W'(719469);
        stamp_o = days * STAMP_W'(86400) + STAMP_W'(hour_i) * STAMP_W'(3600)
                + STAMP_W'(minute_i) * STAMP_W'(60) + STAMP_W'(second_i);
    end
endmodule

module alarm_bank #(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned CHAN_W     = 2,
    parameter int unsigned STAMP_W    = 64,
    parameter int unsigned PERIOD     = 86400,
    parameter int unsigned MAX_ADJ    = 1024
`ifdef ALARM_SNOOZE_EN
    ,
    parameter int unsigned SNOOZE_SEC = 300
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STAMP_W-1:0] counter,
    alarm_bank_if.slave        bus
);
    localparam int unsigned        K_W      = $clog2(MAX_ADJ + 1);
    localparam logic [STAMP_W-1:0] PERIOD_S = STAMP_W'(PERIOD);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_STAMP, S_ADJUST, S_STORE} state_t;

    state_t             state_q, state_d;
    logic [CHAN_W-1:0]  chan_q, chan_d;
    logic               mode_q, mode_d;
    logic [15:0]        year_bcd_q, year_bcd_d;
    logic [7:0]         month_bcd_q, month_bcd_d;
    logic [7:0]         day_bcd_q, day_bcd_d;
    logic [7:0]         hour_bcd_q, hour_bcd_d;
    logic [7:0]         minute_bcd_q, minute_bcd_d;
    logic [7:0]         second_bcd_q, second_bcd_d;
    logic [STAMP_W-1:0] cnt_snap_q, cnt_snap_d;
    logic               err_q, err_d;
    logic [13:0]        year_q, year_d;
    logic [3:0]         month_q, month_d;
    logic [4:0]         day_q, day_d;
    logic [4:0]         hour_q, hour_d;
    logic [5:0]         minute_q, minute_d;
    logic [5:0]         second_q, second_d;
    logic [STAMP_W-1:0] wstamp_q, wstamp_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               ld_done_q, ld_done_d;
    logic               ld_err_q, ld_err_d;
    logic               store_en;
    logic [STAMP_W-1:0] t2s_stamp;

    logic [STAMP_W-1:0]    stamp_q [NUM_ALARMS];
    logic [STAMP_W-1:0]    stamp_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] daily_q, daily_d;
    logic [NUM_ALARMS-1:0] armed_q, armed_d;
    logic [NUM_ALARMS-1:0] ring_q, ring_d;

    function automatic logic bcd2_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [6:0] bcd2_bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [13:0] bcd4_bin(input logic [15:0] b);
        return 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100
             + 14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
    endfunction

    time2stamp #(.STAMP_W(STAMP_W)) u_t2s (
        .year_i   (year_q),
        .month_i  (month_q),
        .day_i    (day_q),
        .hour_i   (hour_q),
        .minute_i (minute_q),
        .second_i (second_q),
        .stamp_o  (t2s_stamp)
    );

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        mode_d       = mode_q;
        year_bcd_d   = year_bcd_q;
        month_bcd_d  = month_bcd_q;
        day_bcd_d    = day_bcd_q;
        hour_bcd_d   = hour_bcd_q;
        minute_bcd_d = minute_bcd_q;
        second_bcd_d = second_bcd_q;
        cnt_snap_d   = cnt_snap_q;
        err_d        = err_q;
        year_d       = year_q;
        month_d      = month_q;
        day_d        = day_q;
        hour_d       = hour_q;
        minute_d     = minute_q;
        second_d     = second_q;
        wstamp_d     = wstamp_q;
        k_d          = k_q;
        ld_done_d    = 1'b0;
        ld_err_d     = 1'b0;
        store_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_valid) begin
                    chan_d       = bus.ld_chan;
                    mode_d       = bus.ld_mode;
                    year_bcd_d   = bus.ld_year_bcd;
                    month_bcd_d  = bus.ld_month_bcd;
                    day_bcd_d    = bus.ld_day_bcd;
                    hour_bcd_d   = bus.ld_hour_bcd;
                    minute_bcd_d = bus.ld_minute_bcd;
                    second_bcd_d = bus.ld_second_bcd;
                    cnt_snap_d   = counter;
                    k_d          = '0;
                    // Malformed requests skip conversion and report straight from STORE.
                    if (32'(bus.ld_chan) >= NUM_ALARMS
                        || !bcd2_ok(bus.ld_year_bcd[15:8]) || !bcd2_ok(bus.ld_year_bcd[7:0])
                        || !bcd2_ok(bus.ld_month_bcd) || !bcd2_ok(bus.ld_day_bcd)
                        || !bcd2_ok(bus.ld_hour_bcd) || !bcd2_ok(bus.ld_minute_bcd)
                        || !bcd2_ok(bus.ld_second_bcd)) begin
                        err_d   = 1'b1;
                        state_d = S_STORE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_CONV;
                    end
                end
            end
            S_CONV: begin
                year_d   = bcd4_bin(year_bcd_q);
                month_d  = 4'(bcd2_bin(month_bcd_q));
                day_d    = 5'(bcd2_bin(day_bcd_q));
                hour_d   = 5'(bcd2_bin(hour_bcd_q));
                minute_d = 6'(bcd2_bin(minute_bcd_q));
                second_d = 6'(bcd2_bin(second_bcd_q));
                state_d  = S_STAMP;
            end
            S_STAMP: begin
                wstamp_d = t2s_stamp;
                state_d  = S_ADJUST;
            end
            S_ADJUST: begin
                if (wstamp_q <= cnt_snap_q) begin
                    if (k_q == K_W'(MAX_ADJ)) begin
                        err_d   = 1'b1;
                        state_d = S_STORE;
                    end else begin
                        wstamp_d = wstamp_q + PERIOD_S;
                        k_d      = k_q + K_W'(1);
                    end
                end else begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                store_en  = !err_q;
                ld_done_d = 1'b1;
                ld_err_d  = err_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-channel update, highest priority first: store, cancel, snooze, match, ack.
    always_comb begin
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            stamp_d[i] = stamp_q[i];
            daily_d[i] = daily_q[i];
            armed_d[i] = armed_q[i];
            ring_d[i]  = ring_q[i];
            if (store_en && chan_q == CHAN_W'(i)) begin
                stamp_d[i] = wstamp_q;
                daily_d[i] = mode_q;
                armed_d[i] = 1'b1;
                ring_d[i]  = 1'b0;
            end else if (bus.cancel_valid && bus.cancel_chan == CHAN_W'(i)) begin
                armed_d[i] = 1'b0;
                ring_d[i]  = 1'b0;
`ifdef ALARM_SNOOZE_EN
            end else if (bus.snooze_valid && bus.snooze_chan == CHAN_W'(i) && ring_q[i]) begin
                stamp_d[i] = counter + STAMP_W'(SNOOZE_SEC);
                armed_d[i] = 1'b1;
                ring_d[i]  = 1'b0;
`endif
            end else if (armed_q[i] && counter >= stamp_q[i]) begin
                ring_d[i] = 1'b1;
                if (daily_q[i]) begin
                    stamp_d[i] = stamp_q[i] + PERIOD_S;
                end else begin
                    armed_d[i] = 1'b0;
                end
            end else if (bus.ack[i]) begin
                ring_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            chan_q       <= '0;
            mode_q       <= 1'b0;
            year_bcd_q   <= '0;
            month_bcd_q  <= '0;
            day_bcd_q    <= '0;
            hour_bcd_q   <= '0;
            minute_bcd_q <= '0;
            second_bcd_q <= '0;
            cnt_snap_q   <= '0;
            err_q        <= 1'b0;
            year_q       <= '0;
            month_q      <= '0;
            day_q        <= '0;
            hour_q       <= '0;
            minute_q     <= '0;
            second_q     <= '0;
            wstamp_q     <= '0;
            k_q          <= '0;
            ld_done_q    <= 1'b0;
            ld_err_q     <= 1'b0;
            daily_q      <= '0;
            armed_q      <= '0;
            ring_q       <= '0;
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            mode_q       <= mode_d;
            year_bcd_q   <= year_bcd_d;
            month_bcd_q  <= month_bcd_d;
            day_bcd_q    <= day_bcd_d;
            hour_bcd_q   <= hour_bcd_d;
            minute_bcd_q <= minute_bcd_d;
            second_bcd_q <= second_bcd_d;
            cnt_snap_q   <= cnt_snap_d;
            err_q        <= err_d;
            year_q       <= year_d;
            month_q      <= month_d;
            day_q        <= day_d;
            hour_q       <= hour_d;
            minute_q     <= minute_d;
            second_q     <= second_d;
            wstamp_q     <= wstamp_d;
            k_q          <= k_d;
            ld_done_q    <= ld_done_d;
            ld_err_q     <= ld_err_d;
            daily_q      <= daily_d;
            armed_q      <= armed_d;
            ring_q       <= ring_d;
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                stamp_q[i] <= stamp_d[i];
            end
        end
    end

    assign bus.ld_ready = (state_q == S_IDLE);
    assign bus.ld_done  = ld_done_q;
    assign bus.ld_err   = ld_err_q;
    assign bus.armed    = armed_q;
    assign bus.ring     = ring_q;
    assign bus.ring_any = |ring_q;
endmodule

// File: tb/tb_alarm_bank.sv
// Directed self-checking bench for alarm_bank (CHAN_W widened to 3 to reach out-of-range channels).
module tb_alarm_bank;
    logic        clk;
    logic        rst;
    logic [63:0] counter;
    logic [63:0] S;
    logic [63:0] P;
    int          n_cmp;
    int          n_fail;

    alarm_bank_if #(.NUM_ALARMS(4), .CHAN_W(3)) bus ();

    alarm_bank #(.NUM_ALARMS(4), .CHAN_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .counter (counter),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference epoch conversion by plain day counting.
    function automatic logic [63:0] ref_stamp(input int y, input int mo, input int d,
                                              input int h, input int mi, input int s);
        int          md [12];
        logic [63:0] days;
        md = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        days = 0;
        for (int yy = 1970; yy < y; yy++)
            days += (((yy % 4 == 0) && (yy % 100 != 0)) || (yy % 400 == 0)) ? 366 : 365;
        for (int m = 1; m < mo; m++) begin
            days += 64'(md[m-1]);
            if (m == 2 && (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0))) days += 1;
        end
        days += 64'(d - 1);
        return days * 86400 + 64'(h * 3600 + mi * 60 + s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] ch, input logic mode, input logic [15:0] yb,
                           input logic [7:0] mob, input logic [7:0] db, input logic [7:0] hb,
                           input logic [7:0] mib, input logic [7:0] sb,
                           output int lat, output logic err);
        int n;
        bus.ld_valid      = 1'b1;
        bus.ld_chan       = ch;
        bus.ld_mode       = mode;
        bus.ld_year_bcd   = yb;
        bus.ld_month_bcd  = mob;
        bus.ld_day_bcd    = db;
        bus.ld_hour_bcd   = hb;
        bus.ld_minute_bcd = mib;
        bus.ld_second_bcd = sb;
        tick();
        bus.ld_valid = 1'b0;
        lat = -1;
        err = 1'bx;
        n   = 0;
        while (lat < 0 && n < 2000) begin
            tick();
            n++;
            if (bus.ld_done === 1'b1) begin
                lat = n;
                err = bus.ld_err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 1", bus.ld_ready); end
        n_cmp++; if (bus.ld_done !== 1'b0) begin n_fail++; $display("FAIL reset_ld_done: got %b expected 0", bus.ld_done); end
        n_cmp++; if (bus.armed !== 4'b0000) begin n_fail++; $display("FAIL reset_armed: got %b expected 0000", bus.armed); end
        n_cmp++; if (bus.ring !== 4'b0000 || bus.ring_any !== 1'b0) begin n_fail++; $display("FAIL reset_ring: got %b/%b expected 0000/0", bus.ring, bus.ring_any); end
    endtask

    task automatic test_load_oneshot();
        int lat; logic err;
        counter = S - 3600;
        do_load(3'd0, 1'b0, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL oneshot_latency: got %0d expected 4", lat); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL oneshot_err: got %b expected 0", err); end
        n_cmp++; if (bus.armed[0] !== 1'b1) begin n_fail++; $display("FAIL oneshot_armed: got %b expected 1", bus.armed[0]); end
        tick();
        n_cmp++; if (bus.ld_done !== 1'b0) begin n_fail++; $display("FAIL ld_done_pulse: got %b expected 0", bus.ld_done); end
        counter = S - 1;
        tick();
        n_cmp++; if (bus.ring[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_early: got %b expected 0", bus.ring[0]); end
        counter = S;
        tick();
        n_cmp++; if (bus.ring[0] !== 1'b1 || bus.ring_any !== 1'b1) begin n_fail++; $display("FAIL oneshot_ring: got %b/%b expected 1/1", bus.ring[0], bus.ring_any); end
        n_cmp++; if (bus.armed[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_disarm: got %b expected 0", bus.armed[0]); end
        bus.ack = 4'b0001;
        tick();
        bus.ack = 4'b0000;
        n_cmp++; if (bus.ring[0] !== 1'b0 || bus.ring_any !== 1'b0) begin n_fail++; $display("FAIL oneshot_ack: got %b/%b expected 0/0", bus.ring[0], bus.ring_any); end
    endtask

    task automatic test_roll_forward();
        int lat; logic err;
        counter = S + 10;
        do_load(3'd1, 1'b1, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 5 || err !== 1'b0) begin n_fail++; $display("FAIL roll_latency: got %0d/%b expected 5/0", lat, err); end
        counter = S + P - 1;
        tick();
        n_cmp++; if (bus.ring[1] !== 1'b0) begin n_fail++; $display("FAIL roll_early: got %b expected 0", bus.ring[1]); end
        counter = S + P;
        tick();
        n_cmp++; if (bus.ring[1] !== 1'b1 || bus.armed[1] !== 1'b1) begin n_fail++; $display("FAIL roll_ring: got %b/%b expected 1/1", bus.ring[1], bus.armed[1]); end
        bus.ack = 4'b0010;
        tick();
        bus.ack = 4'b0000;
        n_cmp++; if (bus.ring[1] !== 1'b0) begin n_fail++; $display("FAIL daily_ack: got %b expected 0", bus.ring[1]); end
        counter = S + 2 * P - 1;
        tick();
        n_cmp++; if (bus.ring[1] !== 1'b0) begin n_fail++; $display("FAIL daily_early: got %b expected 0", bus.ring[1]); end
        counter = S + 2 * P;
        tick();
        n_cmp++; if (bus.ring[1] !== 1'b1) begin n_fail++; $display("FAIL daily_repeat: got %b expected 1", bus.ring[1]); end
        bus.cancel_valid = 1'b1;
        bus.cancel_chan  = 3'd1;
        tick();
        bus.cancel_valid = 1'b0;
        n_cmp++; if (bus.armed[1] !== 1'b0 || bus.ring[1] !== 1'b0) begin n_fail++; $display("FAIL roll_cancel: got %b/%b expected 0/0", bus.armed[1], bus.ring[1]); end
    endtask

    task automatic test_reject();
        int lat; logic err;
        counter = S;
        do_load(3'd0, 1'b0, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 5 || err !== 1'b0) begin n_fail++; $display("FAIL equal_is_past: got %0d/%b expected 5/0", lat, err); end
        do_load(3'd0, 1'b1, 16'h2024, 8'h1A, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL reject_month: got %0d/%b expected 1/1", lat, err); end
        n_cmp++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reject_ready: got %b expected 1", bus.ld_ready); end
        do_load(3'd5, 1'b0, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL reject_chan: got %0d/%b expected 1/1", lat, err); end
        do_load(3'd3, 1'b0, 16'h20A4, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL reject_year: got %0d/%b expected 1/1", lat, err); end
        n_cmp++; if (bus.armed !== 4'b0001) begin n_fail++; $display("FAIL reject_unchanged: got %b expected 0001", bus.armed); end
        counter = S + P;
        tick();
        n_cmp++; if (bus.ring[0] !== 1'b1 || bus.armed[0] !== 1'b0) begin n_fail++; $display("FAIL reject_mode_kept: got %b/%b expected 1/0", bus.ring[0], bus.armed[0]); end
        bus.ack = 4'b0001;
        tick();
        bus.ack = 4'b0000;
    endtask

    task automatic test_simultaneous();
        int lat; logic err;
        counter = S - 100;
        do_load(3'd2, 1'b1, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 4 || err !== 1'b0) begin n_fail++; $display("FAIL sim_load: got %0d/%b expected 4/0", lat, err); end
        counter = S;
        bus.ack = 4'b0100;
        tick();
        bus.ack = 4'b0000;
        n_cmp++; if (bus.ring[2] !== 1'b1 || bus.armed[2] !== 1'b1) begin n_fail++; $display("FAIL match_beats_ack: got %b/%b expected 1/1", bus.ring[2], bus.armed[2]); end
        bus.cancel_valid = 1'b1;
        bus.cancel_chan  = 3'd6;
        tick();
        n_cmp++; if (bus.ring[2] !== 1'b1 || bus.armed[2] !== 1'b1) begin n_fail++; $display("FAIL cancel_oob: got %b/%b expected 1/1", bus.ring[2], bus.armed[2]); end
        bus.cancel_chan = 3'd2;
        tick();
        bus.cancel_valid = 1'b0;
        n_cmp++; if (bus.ring[2] !== 1'b0 || bus.armed[2] !== 1'b0) begin n_fail++; $display("FAIL cancel_ring: got %b/%b expected 0/0", bus.ring[2], bus.armed[2]); end
    endtask

    task automatic test_jump();
        int lat; logic err;
        counter = S - 100;
        do_load(3'd3, 1'b1, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 4 || err !== 1'b0) begin n_fail++; $display("FAIL jump_load: got %0d/%b expected 4/0", lat, err); end
        counter = S + 3 * P;
        tick();
        n_cmp++; if (bus.ring[3] !== 1'b1) begin n_fail++; $display("FAIL jump_ring: got %b expected 1", bus.ring[3]); end
        tick();
        tick();
        tick();
        bus.ack = 4'b1000;
        tick();
        bus.ack = 4'b0000;
        n_cmp++; if (bus.ring[3] !== 1'b0 || bus.armed[3] !== 1'b1) begin n_fail++; $display("FAIL jump_settled: got %b/%b expected 0/1", bus.ring[3], bus.armed[3]); end
        counter = S + 4 * P - 1;
        tick();
        n_cmp++; if (bus.ring[3] !== 1'b0) begin n_fail++; $display("FAIL jump_early: got %b expected 0", bus.ring[3]); end
        counter = S + 4 * P;
        tick();
        n_cmp++; if (bus.ring[3] !== 1'b1) begin n_fail++; $display("FAIL jump_next: got %b expected 1", bus.ring[3]); end
        bus.cancel_valid = 1'b1;
        bus.cancel_chan  = 3'd3;
        tick();
        bus.cancel_valid = 1'b0;
    endtask

    task automatic test_max_adj();
        int lat; logic err;
        counter = S + 1024 * P - 1;
        do_load(3'd0, 1'b0, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 1028 || err !== 1'b0) begin n_fail++; $display("FAIL max_adj_ok: got %0d/%b expected 1028/0", lat, err); end
        counter = S + 1024 * P;
        tick();
        n_cmp++; if (bus.ring[0] !== 1'b1) begin n_fail++; $display("FAIL max_adj_stamp: got %b expected 1", bus.ring[0]); end
        bus.ack = 4'b0001;
        tick();
        bus.ack = 4'b0000;
        do_load(3'd1, 1'b0, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        n_cmp++; if (lat !== 1028 || err !== 1'b1) begin n_fail++; $display("FAIL max_adj_err: got %0d/%b expected 1028/1", lat, err); end
        n_cmp++; if (bus.armed !== 4'b0000) begin n_fail++; $display("FAIL max_adj_armed: got %b expected 0000", bus.armed); end
    endtask

    task automatic test_reset_in_adjust();
        int lat; logic err; int dones;
        counter = S - 100;
        do_load(3'd2, 1'b1, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        counter = S + 500 * P;
        bus.ld_valid = 1'b1;
        bus.ld_chan  = 3'd1;
        bus.ld_mode  = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (bus.ring[2] !== 1'b1 || bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset_state: got %b/%b expected 1/0", bus.ring[2], bus.ld_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.ld_ready !== 1'b1 || bus.ld_done !== 1'b0) begin n_fail++; $display("FAIL rst_adjust_ready: got %b/%b expected 1/0", bus.ld_ready, bus.ld_done); end
        n_cmp++; if (bus.armed !== 4'b0000 || bus.ring !== 4'b0000 || bus.ring_any !== 1'b0) begin n_fail++; $display("FAIL rst_adjust_clear: got %b/%b/%b expected 0000/0000/0", bus.armed, bus.ring, bus.ring_any); end
        dones = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (bus.ld_done === 1'b1) dones++;
        end
        n_cmp++; if (dones !== 0 || bus.armed !== 4'b0000) begin n_fail++; $display("FAIL rst_adjust_discard: got %0d dones/%b expected 0/0000", dones, bus.armed); end
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze();
        int lat; logic err;
        counter = S - 100;
        do_load(3'd0, 1'b0, 16'h2024, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, lat, err);
        counter = S;
        tick();
        n_cmp++; if (bus.ring[0] !== 1'b1) begin n_fail++; $display("FAIL snooze_pre_ring: got %b expected 1", bus.ring[0]); end
        bus.snooze_valid = 1'b1;
        bus.snooze_chan  = 3'd0;
        tick();
        bus.snooze_valid = 1'b0;
        n_cmp++; if (bus.ring[0] !== 1'b0 || bus.armed[0] !== 1'b1) begin n_fail++; $display("FAIL snooze_apply: got %b/%b expected 0/1", bus.ring[0], bus.armed[0]); end
        counter = S + 299;
        tick();
        n_cmp++; if (bus.ring[0] !== 1'b0) begin n_fail++; $display("FAIL snooze_early: got %b expected 0", bus.ring[0]); end
        counter = S + 300;
        tick();
        n_cmp++; if (bus.ring[0] !== 1'b1) begin n_fail++; $display("FAIL snooze_refire: got %b expected 1", bus.ring[0]); end
        bus.snooze_valid = 1'b1;
        bus.snooze_chan  = 3'd1;
        tick();
        bus.snooze_valid = 1'b0;
        n_cmp++; if (bus.armed[1] !== 1'b0) begin n_fail++; $display("FAIL snooze_idle_chan: got %b expected 0", bus.armed[1]); end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        P = 64'd86400;
        S = ref_stamp(2024, 1, 1, 8, 0, 0);
        rst = 1'b1;
        counter = '0;
        bus.ld_valid      = 1'b0;
        bus.ld_chan       = '0;
        bus.ld_mode       = 1'b0;
        bus.ld_year_bcd   = 16'h2024;
        bus.ld_month_bcd  = 8'h01;
        bus.ld_day_bcd    = 8'h01;
        bus.ld_hour_bcd   = 8'h08;
        bus.ld_minute_bcd = 8'h00;
        bus.ld_second_bcd = 8'h00;
        bus.cancel_valid  = 1'b0;
        bus.cancel_chan   = '0;
        bus.ack           = '0;
`ifdef ALARM_SNOOZE_EN
        bus.snooze_valid  = 1'b0;
        bus.snooze_chan   = '0;
`endif
        test_reset();
        test_load_oneshot();
        test_roll_forward();
        test_reject();
        test_simultaneous();
        test_jump();
        test_max_adj();
        test_reset_in_adjust();
`ifdef ALARM_SNOOZE_EN
        test_snooze();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
